// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and default widths for the APB request arbiter.
// The optional ACCESS timeout is enabled with APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PROT_W = 3;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, plus the FSM state for observation.
// Handshake: a request is accepted in the cycle where req_valid[i] && req_ready[i]; fields hold until then.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = apb_arb_pkg::ADDR_W,
    parameter int DATA_W  = apb_arb_pkg::DATA_W
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PROT_W = apb_arb_pkg::PROT_W;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_strb;
    logic [NUM_REQ*PROT_W-1:0] req_prot;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic                      psel;
    logic                      penable;
    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [STRB_W-1:0]         pstrb;
    logic [PROT_W-1:0]         pprot;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;

    apb_arb_pkg::state_t       dbg_state;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output dbg_state
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  dbg_state
    );
endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module apb_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);
    logic [IDX_W-1:0] sel;

    // Scan from farthest to nearest so the nearest hit after ptr is written last.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        sel       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[sel]) begin
                idx       = sel;
                any_valid = 1'b1;
            end
        end
        grant[idx] = any_valid;
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module apb_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = apb_arb_pkg::ADDR_W,
    parameter int DATA_W      = apb_arb_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input logic               pclk,
    input logic               preset,
    apb_req_arbiter_if.master bus
);
    import apb_arb_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, owner, pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any, done, window, timeout;

    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_write;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_strb;
    logic [PROT_W-1:0]  sel_prot;

    apb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] acc_cnt;

    // Counts ACCESS cycles already spent; saturates so it never wraps into a false hit.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            acc_cnt <= '0;
        end else if (state_nxt == ST_SETUP) begin
            acc_cnt <= '0;
        end else if (state == ST_ACCESS && acc_cnt != CNT_W'(TIMEOUT_CYC)) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    assign timeout = (state == ST_ACCESS) && !bus.pready
                     && (acc_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign done          = (state == ST_ACCESS) && bus.pready;
    assign window        = (state == ST_IDLE) || done;
    assign bus.req_ready = window ? pick_grant : '0;
    assign bus.dbg_state = state;

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_write = bus.req_write[i];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_strb  = bus.req_strb[i*STRB_W +: STRB_W];
                sel_prot  = bus.req_prot[i*PROT_W +: PROT_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_any) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (done)         state_nxt = pick_any ? ST_SETUP : ST_IDLE;
                else if (timeout) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.paddr     <= '0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
            bus.pstrb     <= '0;
            bus.pprot     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            ptr           <= IDX_W'(NUM_REQ - 1);
            owner         <= '0;
        end else begin
            bus.psel      <= (state_nxt != ST_IDLE);
            bus.penable   <= (state_nxt == ST_ACCESS);
            bus.rsp_valid <= '0;
            if (done) begin
                bus.rsp_valid <= NUM_REQ'(1) << owner;
                bus.rsp_err   <= bus.pslverr;
                bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
            end else if (timeout) begin
                bus.rsp_valid <= NUM_REQ'(1) << owner;
                bus.rsp_err   <= 1'b1;
                bus.rsp_rdata <= '0;
            end
            if (window && pick_any) begin
                bus.paddr  <= sel_addr;
                bus.pwrite <= sel_write;
                bus.pwdata <= sel_wdata;
                bus.pstrb  <= sel_strb;
                bus.pprot  <= sel_prot;
                ptr        <= pick_idx;
                owner      <= pick_idx;
            end
        end
    end
endmodule
